// File: rtl/sub_pkg.sv
// Shared definitions for the digit-serial subtracter: FSM state encoding
// and elaboration-time helpers for digit count and counter width.
package sub_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of D-bit digits in an N-bit operand.
    function automatic int num_digits(input int n, input int d);
        return n / d;
    endfunction

    // Digit counter width: clog2 of the digit count, never narrower than 1 bit.
    function automatic int cnt_width(input int nd);
        return (nd <= 1) ? 1 : $clog2(nd);
    endfunction

endpackage

// File: rtl/digit_subtracter.sv
// Combinational D-bit borrow-ripple subtraction stage:
// {b_out, diff_dig} = a_dig - b_dig - b_in.
module digit_subtracter
    import sub_pkg::*;
#(
    parameter int D = 2
) (
    input  logic [D-1:0] a_dig,
    input  logic [D-1:0] b_dig,
    input  logic         b_in,
    output logic [D-1:0] diff_dig,
    output logic         b_out
);

    logic [D:0] br;

    // Ripple the borrow from bit 0 upward; each bit is a full subtracter.
    always_comb begin
        br       = '0;
        diff_dig = '0;
        br[0]    = b_in;
        for (int i = 0; i < D; i++) begin
            diff_dig[i] = a_dig[i] ^ b_dig[i] ^ br[i];
            br[i+1]     = (~a_dig[i] & b_dig[i]) | (~(a_dig[i] ^ b_dig[i]) & br[i]);
        end
    end

    assign b_out = br[D];

endmodule

// File: rtl/serial_subtracter.sv
// Digit-serial N-bit subtracter. Operands are latched on an accepted start,
// then consumed D bits per cycle from the LSB upward through a single
// digit_subtracter stage. Results and flags are registered on the last digit
// and held until the next completion.
module serial_subtracter
    import sub_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         b_out,
    output logic         ovf,
    output logic         zero
);

    localparam int NUM_DIGITS = num_digits(N, D);
    localparam int CNT_W      = cnt_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_DIGITS - 1);

    if ((D < 1) || (D > N) || ((N % D) != 0)) begin : g_bad_digit
        $error("serial_subtracter: D must divide N evenly (N=%0d, D=%0d)", N, D);
    end

    state_t           state;
    logic [N-1:0]     a_sh;
    logic [N-1:0]     b_sh;
    logic [N-1:0]     d_sh;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;

    logic [D-1:0]     dig_diff;
    logic             dig_bout;
    logic [N-1:0]     d_next;

    digit_subtracter #(.D(D)) u_digit (
        .a_dig    (a_sh[D-1:0]),
        .b_dig    (b_sh[D-1:0]),
        .b_in     (borrow),
        .diff_dig (dig_diff),
        .b_out    (dig_bout)
    );

    // The new digit enters the difference register from the MSB side, so
    // after the last digit the full result is aligned without a final shift.
    if (D == N) begin : g_single_digit
        assign d_next = dig_diff;
    end else begin : g_multi_digit
        assign d_next = {dig_diff, d_sh[N-1:D]};
    end

    // Control FSM plus operand/result registers; results only change on the
    // last digit so they stay stable while a following operation runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            b_out  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= b_in;
                        a_msb  <= a[N-1];
                        b_msb  <= b[N-1];
                        cnt    <= CNT_LOAD;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> D;
                    b_sh   <= b_sh >> D;
                    d_sh   <= d_next;
                    borrow <= dig_bout;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        diff  <= d_next;
                        b_out <= dig_bout;
                        ovf   <= (a_msb ^ b_msb) & (a_msb ^ d_next[N-1]);
                        zero  <= (d_next == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        done <= 1'b0;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtracter.sv
// Scoreboard bench for serial_subtracter: directed N=8/D=2 vectors with
// hand-computed results, plus exhaustive N=4 sweeps for D=1, 2 and 4.
module tb_serial_subtracter;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        logic       zero;
        int         issue;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        logic       zero;
        bit         hold;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic       rst_n;
    logic       rst4_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       b_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       b_out;
    logic       ovf;
    logic       zero;

    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] held_diff;

    serial_subtracter #(.N(8), .D(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf),
        .zero  (zero)
    );

    // a, b, b_in, diff, b_out, ovf, zero, hold-start
    vec_t vecs[12] = '{
        '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0},
        '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0},
        '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0},
        '{8'h42, 8'h41, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0},
        '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0},
        '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0},
        '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1},
        '{8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1},
        '{8'h90, 8'h20, 1'b0, 8'h70, 1'b0, 1'b1, 1'b0, 1'b1},
        '{8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1},
        '{8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0},
        '{8'h9C, 8'h1D, 1'b1, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0}
    };
    vec_t abort_v = '{8'hC3, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Integer reference for an n-bit a - b - bin.
    function automatic exp_t model(input int n, input int ua, input int ub, input int bin);
        exp_t e;
        int   mask, r, sa, sb, s;
        mask   = (1 << n) - 1;
        r      = ua - ub - bin;
        e.diff = 8'(r & mask);
        e.bout = (r < 0);
        sa     = (ua >= (1 << (n - 1))) ? ua - (1 << n) : ua;
        sb     = (ub >= (1 << (n - 1))) ? ub - (1 << n) : ub;
        s      = sa - sb - bin;
        e.ovf  = (s < -(1 << (n - 1))) || (s > (1 << (n - 1)) - 1);
        e.zero = ((r & mask) == 0);
        e.issue = 0;
        return e;
    endfunction

    // Wait for idle at a negedge, present operands with start, optionally
    // record the expected result, then scramble operands one cycle later.
    task automatic issue(input vec_t v, input bit exp_on);
        int   guard;
        exp_t e;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL main_issue_timeout: busy=%0b required 0", busy);
        end
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        b_in  = v.bin;
        if (exp_on) begin
            e.diff  = v.diff;
            e.bout  = v.bout;
            e.ovf   = v.ovf;
            e.zero  = v.zero;
            e.issue = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        if (!v.hold) start = 1'b0;
        a    = 8'($urandom);
        b    = 8'($urandom);
        b_in = 1'($urandom);
    endtask

    // Main monitor: check each completion against the scoreboard and check
    // that the result register holds while the next operation runs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL main_unexpected_done: done=1 required 0 (no pending op)");
                end else begin
                    mon_e = q.pop_front();
                    chk("main_diff", 32'(diff), 32'(mon_e.diff));
                    chk("main_b_out", 32'(b_out), 32'(mon_e.bout));
                    chk("main_ovf", 32'(ovf), 32'(mon_e.ovf));
                    chk("main_zero", 32'(zero), 32'(mon_e.zero));
                    chk("main_latency", 32'(cyc - mon_e.issue), 32'd4);
                    held_diff = mon_e.diff;
                end
            end else if (busy) begin
                chk("main_hold_diff", 32'(diff), 32'(held_diff));
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_x
        localparam int DG  = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int NDG = 4 / DG;

        logic       start_x;
        logic [3:0] a_x;
        logic [3:0] b_x;
        logic       bin_x;
        logic       busy_x;
        logic       done_x;
        logic [3:0] diff_x;
        logic       bout_x;
        logic       ovf_x;
        logic       zero_x;
        exp_t       qx[$];
        exp_t       ex;
        bit         fin = 1'b0;

        serial_subtracter #(.N(4), .D(DG)) u_dut (
            .clk   (clk),
            .rst_n (rst4_n),
            .start (start_x),
            .a     (a_x),
            .b     (b_x),
            .b_in  (bin_x),
            .busy  (busy_x),
            .done  (done_x),
            .diff  (diff_x),
            .b_out (bout_x),
            .ovf   (ovf_x),
            .zero  (zero_x)
        );

        // Sweep every {b_in, a, b} with start held high, back-to-back.
        initial begin
            start_x = 1'b0;
            a_x     = '0;
            b_x     = '0;
            bin_x   = 1'b0;
            @(posedge rst4_n);
            @(negedge clk);
            for (int i = 0; i < 512; i++) begin
                int   guard;
                exp_t e;
                guard = 0;
                while (busy_x && guard < 64) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 64) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL x%0d_issue_timeout: busy=%0b required 0", DG, busy_x);
                end
                start_x = 1'b1;
                bin_x   = i[8];
                a_x     = i[7:4];
                b_x     = i[3:0];
                e       = model(4, int'(i[7:4]), int'(i[3:0]), int'(i[8]));
                e.issue = cyc + 1;
                qx.push_back(e);
                @(negedge clk);
                a_x   = 4'($urandom);
                b_x   = 4'($urandom);
                bin_x = 1'($urandom);
            end
            start_x = 1'b0;
            for (int k = 0; k < 64 && qx.size() != 0; k++) @(negedge clk);
            fin = 1'b1;
        end

        always @(negedge clk) begin
            if (rst4_n && done_x) begin
                if (qx.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL x%0d_unexpected_done: done=1 required 0", DG);
                end else begin
                    ex = qx.pop_front();
                    chk($sformatf("x%0d_diff", DG), 32'(diff_x), 32'(ex.diff));
                    chk($sformatf("x%0d_b_out", DG), 32'(bout_x), 32'(ex.bout));
                    chk($sformatf("x%0d_ovf", DG), 32'(ovf_x), 32'(ex.ovf));
                    chk($sformatf("x%0d_zero", DG), 32'(zero_x), 32'(ex.zero));
                    chk($sformatf("x%0d_latency", DG), 32'(cyc - ex.issue), 32'(NDG));
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        rst4_n    = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;
        held_diff = '0;
        repeat (2) @(negedge clk);
        a  = 8'hFF;
        b  = 8'h01;
        start = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_b_out", 32'(b_out), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_zero", 32'(zero), 32'd0);
        start  = 1'b0;
        rst_n  = 1'b1;
        rst4_n = 1'b1;

        for (int i = 0; i < 10; i++) issue(vecs[i], 1'b1);
        start = 1'b0;

        issue(vecs[10], 1'b1);
        issue(abort_v, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_b_out", 32'(b_out), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        held_diff = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(vecs[11], 1'b1);
        start = 1'b0;

        for (int k = 0; k < 20000; k++) begin
            if (q.size() == 0 && g_x[0].fin && g_x[1].fin && g_x[2].fin) break;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL main_drain: pending=%0d required 0", q.size());
        end
        if (!(g_x[0].fin && g_x[1].fin && g_x[2].fin) || g_x[0].qx.size() != 0 ||
            g_x[1].qx.size() != 0 || g_x[2].qx.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sweep_drain: pending=%0d/%0d/%0d required 0/0/0",
                     g_x[0].qx.size(), g_x[1].qx.size(), g_x[2].qx.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
